gate_level_allot: RTL and testbench

- Automated hospital reception-desk allotter for two doctors.
- Each clock it samples a 2-bit patient query, detects a new request, and assigns a free doctor or issues a wait code.
- It holds each assigned doctor busy for a fixed consultation time: 15 s = 15 clock cycles at the system clock.
- Sits between the desk input logic and the display/announcement logic.

---
 rtl/gate_level_allot_pkg.sv | 45 ++++
 rtl/gate_level_allot_doctor_busy_timer.sv | 37 +++
 rtl/gate_level_allot.sv | 72 +++++++
 tb/tb_gate_level_allot.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/gate_level_allot_pkg.sv
// Shared codes and allocation priority for the two-doctor reception allotter.
// Query and desk-response encodings plus the default consultation length.
package gate_level_allot_pkg;

    typedef enum logic [1:0] {
        Q_NONE = 2'b00,
        Q_DOC1 = 2'b01,
        Q_DOC2 = 2'b10,
        Q_ANY  = 2'b11
    } query_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'b00,
        M_DOC1 = 2'b01,
        M_DOC2 = 2'b10,
        M_WAIT = 2'b11
    } msg_e;

    localparam int DEF_CONSULT_CYCLES = 15;

    // Doctor 2 is tried first only for an explicit doctor-2 preference.
    function automatic msg_e allot(
        input logic [1:0] q,
        input logic       free1,
        input logic       free2
    );
        msg_e r;
        r = M_WAIT;
        if (q == Q_DOC2) begin
            if (free2) begin
                r = M_DOC2;
            end else if (free1) begin
                r = M_DOC1;
            end
        end else begin
            if (free1) begin
                r = M_DOC1;
            end else if (free2) begin
                r = M_DOC2;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_level_allot_doctor_busy_timer.sv
// Per-doctor consultation timer: loads on allotment, counts down to zero.
// busy is decoded from the count register so it never glitches.
module doctor_busy_timer
    import gate_level_allot_pkg::*;
#(
    parameter  int CONSULT_CYCLES = DEF_CONSULT_CYCLES,
    localparam int CNT_W          = $clog2(CONSULT_CYCLES + 1)
) (
    input  logic clk,
    input  logic start,
    input  logic load,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(CONSULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/gate_level_allot.sv
// Reception-desk allotter: detects new patient requests and assigns
// one of two doctors, or answers wait when both are in consultation.
module gate_level_allot
    import gate_level_allot_pkg::*;
#(
    parameter int CONSULT_CYCLES = DEF_CONSULT_CYCLES
) (
    input  logic       clk,
    input  logic       start,
    input  logic [1:0] query,
    output logic       A,
    output logic       B,
    output logic [1:0] message
);

    logic [1:0] prev_q;
    msg_e       msg_q;
    msg_e       msg_d;
    msg_e       grant;
    logic       req;
    logic       busy1;
    logic       busy2;
    logic       load1;
    logic       load2;

    // A held query counts once; any change to a nonzero code re-requests.
    assign req = (query != Q_NONE) && (query != prev_q);

    always_comb begin
        grant = allot(query, !busy1, !busy2);
        msg_d = msg_q;
        if (req) begin
            msg_d = grant;
        end
    end

    assign load1 = req && (grant == M_DOC1);
    assign load2 = req && (grant == M_DOC2);

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            prev_q <= Q_NONE;
            msg_q  <= M_IDLE;
        end else begin
            prev_q <= query;
            msg_q  <= msg_d;
        end
    end

    doctor_busy_timer #(
        .CONSULT_CYCLES(CONSULT_CYCLES)
    ) u_doc1 (
        .clk  (clk),
        .start(start),
        .load (load1),
        .busy (busy1)
    );

    doctor_busy_timer #(
        .CONSULT_CYCLES(CONSULT_CYCLES)
    ) u_doc2 (
        .clk  (clk),
        .start(start),
        .load (load2),
        .busy (busy2)
    );

    assign A       = busy1;
    assign B       = busy2;
    assign message = msg_q;

endmodule

// File: tb/tb_gate_level_allot.sv
// Directed-vector bench for the two-doctor allotter.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_gate_level_allot;

    logic       clk;
    logic       start;
    logic [1:0] query;
    logic       A;
    logic       B;
    logic [1:0] message;

    int vectors;
    int miscompares;

    gate_level_allot dut (
        .clk    (clk),
        .start  (start),
        .query  (query),
        .A      (A),
        .B      (B),
        .message(message)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic a_e,
                           input logic b_e, input logic [1:0] m_e);
        chk({tag, ".A"}, {1'b0, A}, {1'b0, a_e});
        chk({tag, ".B"}, {1'b0, B}, {1'b0, b_e});
        chk({tag, ".msg"}, message, m_e);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start       = 1'b1;
        query       = 2'b11;

        // reset; the request presented during reset is lost
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b0, 2'b00);
        query = 2'b00;
        start = 1'b0;
        tick();
        chk_all("idle", 1'b0, 1'b0, 2'b00);

        // query 11 held 5 cycles: doctor 1, A high for exactly 15 cycles
        query = 2'b11;
        tick();
        chk_all("hold.1", 1'b1, 1'b0, 2'b01);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk_all("hold.n", 1'b1, 1'b0, 2'b01);
        end
        query = 2'b00;
        for (int i = 6; i <= 15; i++) begin
            tick();
            chk_all("busy1", 1'b1, 1'b0, 2'b01);
        end
        tick();
        chk_all("free1", 1'b0, 1'b0, 2'b01);

        // two requests two cycles apart, then a third while both busy
        query = 2'b11;
        tick();
        chk_all("req1", 1'b1, 1'b0, 2'b01);
        query = 2'b00;
        tick();
        chk_all("gap1", 1'b1, 1'b0, 2'b01);
        query = 2'b11;
        tick();
        chk_all("req2", 1'b1, 1'b1, 2'b10);
        query = 2'b00;
        tick();
        chk_all("gap2", 1'b1, 1'b1, 2'b10);
        query = 2'b11;
        tick();
        chk_all("req3wait", 1'b1, 1'b1, 2'b11);
        query = 2'b00;
        // doctor 2 was loaded 2 edges ago: 13 left, doctor 1 has 11 left
        for (int i = 0; i < 11; i++) tick();
        chk_all("d1done", 1'b0, 1'b1, 2'b11);
        tick();
        tick();
        chk_all("d2done", 1'b0, 1'b0, 2'b11);

        // preference for doctor 2, then direct change to 01
        query = 2'b10;
        tick();
        chk_all("pref2", 1'b0, 1'b1, 2'b10);
        query = 2'b01;
        tick();
        chk_all("pref1", 1'b1, 1'b1, 2'b01);

        // doctor 1 loaded at edge c; 14 idle edges leave it at count 1
        query = 2'b00;
        for (int i = 0; i < 14; i++) tick();
        chk_all("cnt1is1", 1'b1, 1'b0, 2'b01);
        query = 2'b01;
        tick();
        chk_all("edgebusy", 1'b0, 1'b1, 2'b10);
        query = 2'b11;
        tick();
        chk_all("reload", 1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 13; i++) tick();
        chk_all("reloaded", 1'b1, 1'b1, 2'b01);

        // asynchronous reset mid-consultation, checked before any edge
        query = 2'b00;
        start = 1'b1;
        #1;
        chk_all("async", 1'b0, 1'b0, 2'b00);
        tick();
        start = 1'b0;
        tick();
        chk_all("postrst", 1'b0, 1'b0, 2'b00);
        query = 2'b11;
        tick();
        chk_all("afterrst", 1'b1, 1'b0, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
